alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Issue controller that drives the 13-way ALU result multiplexer (ADD..NEG, 4-bit select, enable).
- Accepts one instruction at a time (opcode plus two operands) over a valid/ready handshake.
- Presents the operands to the ALU and asserts the mux enable and select for exactly one cycle.
- Captures the muxed 8-bit result and returns it with Z/N/error flags over a second valid/ready handshake.
- Sits between the instruction source and the ALU datapath.

Parameters:
DATA_W, 8, operand/result width; must match the mux data width.
OP_W, 4, opcode/select width.
NUM_OPS, 13, number of legal opcodes (0..NUM_OPS-1); opcodes at or above NUM_OPS are illegal.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
in_valid  input  1  instruction valid.
in_ready  output  1  controller can accept an instruction.
in_op  input  OP_W  opcode (0=ADD 1=SUB 2=SHL 3=SHR 4=CMP 5=AND 6=OR 7=XOR 8=NAND 9=NOR 10=XNOR 11=INV 12=NEG).
in_a  input  DATA_W  operand A.
in_b  input  DATA_W  operand B.
alu_a  output  DATA_W  operand A to the ALU units.
alu_b  output  DATA_W  operand B to the ALU units.
alu_sel  output  OP_W  mux select.
alu_en  output  1  mux enable.
alu_result  input  DATA_W  mux output; combinational path from alu_a/alu_b/alu_sel/alu_en.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_data  output  DATA_W  captured result.
out_z  output  1  out_data == 0.
out_n  output  1  out_data[DATA_W-1].
out_err  output  1  illegal opcode.

Behaviour:
- FSM states: IDLE, ISSUE, DONE. Next-state and output assignments are registered, except in_ready.
- in_ready = rst_n && (state == IDLE). It is combinational and never asserted outside IDLE.
- IDLE:
  - On in_valid && in_ready, latch in_op, in_a, in_b.
  - Legal opcode -> next state ISSUE.
  - Opcode >= NUM_OPS -> next state DONE with out_data=0, out_z=1, out_n=0, out_err=1. The ALU is not enabled.
- ISSUE (exactly 1 cycle):
  - alu_en=1; alu_sel, alu_a, alu_b = latched values.
  - At the closing edge: out_data <= alu_result, out_z <= (alu_result==0), out_n <= alu_result[DATA_W-1], out_err <= 0.
  - Next state DONE.
- DONE:
  - out_valid=1; out_data and flags held stable.
  - On out_ready: out_valid drops at the next edge and the state returns to IDLE.
  - No new instruction is accepted in the same cycle as the result handshake.
- Latency, with accept at edge 0:
  - Legal opcode: alu_en high in cycle 1; out_valid high from cycle 2.
  - Illegal opcode: out_valid high from cycle 1.
  - Maximum throughput is 1 legal instruction per 3 cycles when out_ready is held high.
- ALU-side outputs outside ISSUE: alu_en=0; alu_sel, alu_a, alu_b hold their last issued values (no toggling).
- Backpressure: with out_ready low, the controller stays in DONE indefinitely, in_ready stays 0, and outputs do not change.
- Reset (rst_n=0 at a rising edge), in any state including mid-ISSUE or DONE:
  - Next state IDLE.
  - alu_en, out_valid, out_err, out_n <= 0; out_z <= 0.
  - alu_sel, alu_a, alu_b, out_data <= 0.
  - A pending result is discarded and never presented.

Optional Feature:
Macro ALU_ISSUE_STATS_EN.
- Defined:
  - Adds outputs stat_issued [15:0] and stat_illegal [15:0].
  - stat_issued increments on each ISSUE cycle; stat_illegal increments on each illegal-opcode accept.
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then ADD (op 0, a=0x12, b=0x34), bench ALU model returns a+b -> alu_en high exactly 1 cycle with alu_sel=0, alu_a=0x12, alu_b=0x34; out_valid 2 cycles after accept; out_data=0x46, out_z=0, out_n=0, out_err=0.
- SUB (op 1, a=0x55, b=0x55) -> out_data=0x00, out_z=1; then NEG (op 12, a=0x01) -> out_data=0xFF, out_n=1.
- Illegal op 0xD with a=0xAA -> alu_en never asserts; out_valid 1 cycle after accept; out_data=0x00, out_err=1, out_z=1.
- XOR (op 7, a=0xF0, b=0x3C) with out_ready low for 5 cycles -> out_data=0xCC stable throughout, in_ready=0, and an in_valid offered meanwhile is not accepted; after out_ready, in_ready returns the following cycle.
- Assert rst_n=0 during the ISSUE cycle of an AND -> next cycle all outputs zero, out_valid never asserts for that instruction, in_ready=1 once rst_n=1.
- With ALU_ISSUE_STATS_EN: 3 legal and 2 illegal instructions -> stat_issued=3, stat_illegal=2; counters return to 0 after reset.

Source files
------------

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction, ALU-mux and result handshakes for alu_issue_ctrl (master = environment, slave = controller)
interface alu_issue_if #(parameter int DATA_W = 8, parameter int OP_W = 4);
  logic in_valid;
  logic in_ready;
  logic [OP_W-1:0] in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0] alu_sel;
  logic alu_en;
  logic [DATA_W-1:0] alu_result;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic out_z;
  logic out_n;
  logic out_err;
  modport master (
    output in_valid, in_op, in_a, in_b, alu_result, out_ready,
    input in_ready, alu_a, alu_b, alu_sel, alu_en, out_valid, out_data, out_z, out_n, out_err
  );
  modport slave (
    input in_valid, in_op, in_a, in_b, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, alu_en, out_valid, out_data, out_z, out_n, out_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue ALU mux controller; define ALU_ISSUE_STATS_EN for issue/illegal counters
module alu_issue_ctrl #(
  parameter int DATA_W = 8,
  parameter int OP_W = 4,
  parameter int NUM_OPS = 13
) (
  input logic clk,
  input logic rst_n,
  alu_issue_if.slave bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_illegal
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state;
  logic legal;
  assign bus.in_ready = rst_n && state == IDLE;
  assign legal = int'(bus.in_op) < NUM_OPS;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.alu_en <= 1'b0;
      bus.alu_sel <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_z <= 1'b0;
      bus.out_n <= 1'b0;
      bus.out_err <= 1'b0;
`ifdef ALU_ISSUE_STATS_EN
      stat_issued <= '0;
      stat_illegal <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          // ALU operands only move on a legal accept so they hold the last issued values
          if (legal) begin
            state <= ISSUE;
            bus.alu_en <= 1'b1;
            bus.alu_sel <= bus.in_op;
            bus.alu_a <= bus.in_a;
            bus.alu_b <= bus.in_b;
          end else begin
            state <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_data <= '0;
            bus.out_z <= 1'b1;
            bus.out_n <= 1'b0;
            bus.out_err <= 1'b1;
`ifdef ALU_ISSUE_STATS_EN
            if (stat_illegal != 16'hFFFF) stat_illegal <= stat_illegal + 16'd1;
`endif
          end
        end
        ISSUE: begin
          state <= DONE;
          bus.alu_en <= 1'b0;
          bus.out_valid <= 1'b1;
          bus.out_data <= bus.alu_result;
          bus.out_z <= bus.alu_result == '0;
          bus.out_n <= bus.alu_result[DATA_W-1];
          bus.out_err <= 1'b0;
`ifdef ALU_ISSUE_STATS_EN
          if (stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
`endif
        end
        DONE: if (bus.out_ready) begin
          state <= IDLE;
          bus.out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
